// File: rtl/vboard_gpio_ctrl.sv
// rtl/vboard_gpio_ctrl.sv - board GPIO controller: direction/output registers, debounced inputs, edge interrupts
module vboard_gpio_ctrl #(
    parameter int                GPIO_NUMS   = 32,
    parameter int                SYNC_STAGES = 2,
    parameter int                DEB_W       = 8,
    parameter logic [31:0]       DIR_RESET   = 32'h000001FF,
    parameter logic [DEB_W-1:0]  DEB_RESET   = DEB_W'(4)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           bus_addr,
    input  logic [31:0]          bus_wdata,
    input  logic                 bus_we,
    input  logic                 bus_re,
    output logic [31:0]          bus_rdata,
    output logic                 bus_ready,
    input  logic [GPIO_NUMS-1:0] pad_in,
    output logic [GPIO_NUMS-1:0] pad_out,
    output logic [GPIO_NUMS-1:0] pad_oe,
    output logic                 irq
);

    localparam logic [2:0] A_DIR    = 3'd0;
    localparam logic [2:0] A_OUT    = 3'd1;
    localparam logic [2:0] A_IN     = 3'd2;
    localparam logic [2:0] A_RISE   = 3'd3;
    localparam logic [2:0] A_FALL   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
    localparam logic [2:0] A_DEB    = 3'd6;
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

    logic [GPIO_NUMS-1:0] dir_q, out_q, rise_en_q, fall_en_q, status_q;
    logic [GPIO_NUMS-1:0] stable_q, stable_d;
    logic [DEB_W-1:0]     deb_q;
    logic [GPIO_NUMS-1:0] sync_q [SYNC_STAGES];
    logic [DEB_W-1:0]     cnt_q  [GPIO_NUMS];

    logic [2:0]           reg_sel;
    logic [GPIO_NUMS-1:0] wr_bits, w1c, set_bits, smp;
    logic [31:0]          rd_val;
    logic [DEB_W-1:0]     lim_m1;
    logic                 unused_addr;

    assign reg_sel     = bus_addr[4:2];
    assign wr_bits     = bus_wdata[GPIO_NUMS-1:0];
    assign unused_addr = ^bus_addr[1:0];
    assign smp         = sync_q[SYNC_STAGES-1];
    assign w1c         = (bus_we && reg_sel == A_STATUS) ? wr_bits : '0;
    assign set_bits    = (stable_q & ~stable_d & rise_en_q) | (~stable_q & stable_d & fall_en_q);
    // A zero limit behaves as one: the pin follows the synchronised sample directly.
    assign lim_m1      = (deb_q == '0) ? '0 : deb_q - DEB_ONE;

    function automatic logic [31:0] zext(input logic [GPIO_NUMS-1:0] v);
        zext = '0;
        zext[GPIO_NUMS-1:0] = v;
    endfunction

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            A_DIR:    rd_val = zext(dir_q);
            A_OUT:    rd_val = zext(out_q);
            A_IN:     rd_val = zext(stable_q);
            A_RISE:   rd_val = zext(rise_en_q);
            A_FALL:   rd_val = zext(fall_en_q);
            A_STATUS: rd_val = zext(status_q);
            A_DEB:    rd_val[DEB_W-1:0] = deb_q;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q     <= DIR_RESET[GPIO_NUMS-1:0];
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            deb_q     <= DEB_RESET;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
            irq       <= 1'b0;
            pad_oe    <= DIR_RESET[GPIO_NUMS-1:0];
            pad_out   <= '0;
        end else begin
            bus_ready <= bus_we | bus_re;
            bus_rdata <= bus_re ? rd_val : '0;
            if (bus_we) begin
                case (reg_sel)
                    A_DIR:   dir_q     <= wr_bits;
                    A_OUT:   out_q     <= wr_bits;
                    A_RISE:  rise_en_q <= wr_bits;
                    A_FALL:  fall_en_q <= wr_bits;
                    A_DEB:   deb_q     <= bus_wdata[DEB_W-1:0];
                    default: ;
                endcase
            end
            // New edges override a same-cycle clear so no event is lost.
            status_q  <= (status_q & ~w1c) | set_bits;
            irq       <= |status_q;
            pad_oe    <= dir_q;
            pad_out   <= out_q & dir_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < GPIO_NUMS; i++) cnt_q[i] <= '0;
            stable_q <= '0;
            stable_d <= '0;
        end else begin
            sync_q[0] <= pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            stable_d <= stable_q;
            for (int i = 0; i < GPIO_NUMS; i++) begin
                if (smp[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= lim_m1) begin
                    stable_q[i] <= smp[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DEB_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vboard_gpio_ctrl.sv
// tb/tb_vboard_gpio_ctrl.sv - self-checking bench for vboard_gpio_ctrl
module tb_vboard_gpio_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [31:0] pad_in = '0;
    logic [31:0] pad_out;
    logic [31:0] pad_oe;
    logic        irq;

    vboard_gpio_ctrl dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: registers as plain words, pads seen S samples late,
    // a pin's stable value flips after L consecutive differing samples.
    logic [31:0] m_dir, m_out, m_rise, m_fall, m_status, m_stable, m_pend_r, m_pend_f;
    logic [7:0]  m_deb;
    int          m_run [32];
    logic [31:0] m_hist [S];
    logic        m_ready, m_irq;
    logic [31:0] m_rdata, m_oe, m_pout;
    logic [31:0] t_rd, t_s, t_new, t_set, t_clr;
    int          t_lim;

    always @(posedge clk) begin
        if (!rst) begin
            m_dir = 32'h1FF; m_out = 0; m_rise = 0; m_fall = 0; m_status = 0;
            m_deb = 8'd4; m_stable = 0; m_pend_r = 0; m_pend_f = 0;
            for (int i = 0; i < 32; i++) m_run[i] = 0;
            for (int k = 0; k < S; k++) m_hist[k] = 0;
            m_ready = 0; m_rdata = 0; m_irq = 0; m_oe = 32'h1FF; m_pout = 0;
        end else begin
            case (bus_addr[4:2])
                3'd0: t_rd = m_dir;
                3'd1: t_rd = m_out;
                3'd2: t_rd = m_stable;
                3'd3: t_rd = m_rise;
                3'd4: t_rd = m_fall;
                3'd5: t_rd = m_status;
                3'd6: t_rd = {24'd0, m_deb};
                default: t_rd = 0;
            endcase
            m_ready = bus_we | bus_re;
            m_rdata = bus_re ? t_rd : 32'd0;
            m_irq   = (m_status != 0);
            m_oe    = m_dir;
            m_pout  = m_out & m_dir;
            t_set = (m_pend_r & m_rise) | (m_pend_f & m_fall);
            t_clr = (bus_we && bus_addr[4:2] == 3'd5) ? bus_wdata : 32'd0;
            m_status = (m_status & ~t_clr) | t_set;
            t_lim = (m_deb == 0) ? 1 : int'(m_deb);
            t_s = m_hist[S-1];
            t_new = m_stable;
            for (int i = 0; i < 32; i++) begin
                if (t_s[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= t_lim) begin
                        t_new[i] = t_s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pend_r = t_new & ~m_stable;
            m_pend_f = ~t_new & m_stable;
            m_stable = t_new;
            for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pad_in;
            if (bus_we) begin
                case (bus_addr[4:2])
                    3'd0: m_dir  = bus_wdata;
                    3'd1: m_out  = bus_wdata;
                    3'd3: m_rise = bus_wdata;
                    3'd4: m_fall = bus_wdata;
                    3'd6: m_deb  = bus_wdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",   {31'd0, bus_ready}, {31'd0, m_ready});
            chk("rdata",   bus_rdata, m_rdata);
            chk("pad_oe",  pad_oe, m_oe);
            chk("pad_out", pad_out, m_pout);
            chk("irq",     {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus_addr = a; bus_re = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
        chk({name, "_ready"}, {31'd0, bus_ready}, 32'd1);
        chk(name, bus_rdata, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [2:0] ra;
    int         op;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        tick(2);
        chk_en = 1'b1;
        rst = 1'b1;
        chk("rst_pad_oe", pad_oe, 32'h1FF);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk(5'h00, 32'h1FF, "rst_dir");
        rd_chk(5'h04, 32'h0, "rst_out");
        rd_chk(5'h08, 32'h0, "rst_in");
        rd_chk(5'h0C, 32'h0, "rst_rise");
        rd_chk(5'h10, 32'h0, "rst_fall");
        rd_chk(5'h14, 32'h0, "rst_status");
        rd_chk(5'h18, 32'h4, "rst_deb");
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, bus_ready}, 32'd0);

        wr(5'h00, 32'h0000000F);
        wr(5'h04, 32'hFFFF00A5);
        chk("pad_out_pre", pad_out, 32'h0);
        chk("pad_oe_drive", pad_oe, 32'hF);
        tick(1);
        chk("pad_out_drive", pad_out, 32'h5);

        @(negedge clk); pad_in[12] = 1'b1;
        tick(3);        pad_in[12] = 1'b0;
        tick(8);
        rd_chk(5'h08, 32'h0, "glitch_in");

        wr(5'h0C, 32'h1000);
        @(negedge clk); pad_in[12] = 1'b1;
        tick(5);
        bus_addr = 5'h08; bus_re = 1'b1;
        @(negedge clk);
        chk("in_before", bus_rdata, 32'h0);
        @(negedge clk);
        bus_re = 1'b0;
        chk("in_after", bus_rdata, 32'h1000);
        chk("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd_chk(5'h14, 32'h1000, "status_rise");

        pad_in[12] = 1'b0;
        tick(10);
        rd_chk(5'h14, 32'h1000, "status_fall_off");
        rd_chk(5'h08, 32'h0, "in_fall");

        @(negedge clk); pad_in[12] = 1'b1;
        tick(6);
        bus_addr = 5'h14; bus_wdata = 32'h1000; bus_we = 1'b1;
        @(negedge clk); bus_we = 1'b0;
        tick(1);
        rd_chk(5'h14, 32'h1000, "w1c_race");
        wr(5'h14, 32'h1000);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        tick(1);
        chk("irq_clear", {31'd0, irq}, 32'd0);
        rd_chk(5'h14, 32'h0, "status_clear");

        wr(5'h18, 32'h0);
        @(negedge clk); pad_in[12] = 1'b0;
        @(negedge clk); pad_in[12] = 1'b1;
        tick(2);
        bus_addr = 5'h08; bus_re = 1'b1;
        @(negedge clk);
        chk("deb0_low", bus_rdata, 32'h0);
        @(negedge clk);
        bus_re = 1'b0;
        chk("deb0_high", bus_rdata, 32'h1000);

        @(negedge clk);
        bus_addr = 5'h04; bus_wdata = 32'h12345678; bus_we = 1'b1; bus_re = 1'b1;
        @(negedge clk);
        bus_we = 1'b0; bus_re = 1'b0;
        chk("we_re_old", bus_rdata, 32'hFFFF00A5);
        rd_chk(5'h04, 32'h12345678, "out_new");
        rd_chk(5'h1C, 32'h0, "unmapped");

        wr(5'h18, 32'h4);
        wr(5'h14, 32'hFFFFFFFF);
        @(negedge clk); pad_in[12] = 1'b0;
        tick(10);
        wr(5'h14, 32'hFFFFFFFF);
        @(negedge clk); pad_in[12] = 1'b1;
        tick(3);
        rst = 1'b0; pad_in[12] = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(10);
        rd_chk(5'h08, 32'h0, "rstmid_in");
        rd_chk(5'h14, 32'h0, "rstmid_status");
        rd_chk(5'h00, 32'h1FF, "rstmid_dir");
        chk("rstmid_irq", {31'd0, irq}, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 3) == 0) pad_in ^= ($urandom & $urandom & $urandom);
            op = $urandom_range(0, 4);
            ra = 3'($urandom_range(0, 7));
            bus_addr  = {ra, 2'($urandom_range(0, 3))};
            bus_wdata = (ra == 3'd6) ? 32'($urandom_range(0, 5)) : $urandom;
            bus_we = (op == 1 || op == 3);
            bus_re = (op == 2 || op == 3);
        end
        @(negedge clk);
        rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
